// File: rtl/uart_pkg.sv
// Shared UART types, constants and tick-generator sizing helpers.
package uart_pkg;

  typedef enum logic [3:0] {
    IDLE, START, D0, D1, D2, D3, D4, D5, D6, D7, STOP, WAIT_HIGH
  } rx_state_t;

  localparam int         DATA_BITS  = 8;
  localparam logic [1:0] FILTER_MAX = 2'd3;

  function automatic int tickGcd(input int a, input int b);
    int x, y, t;
    x = a;
    y = b;
    while (y != 0) begin
      t = x % y;
      x = y;
      y = t;
    end
    return x;
  endfunction

  // Accumulator runs modulo clk/gcd, adding rate/gcd each clk: exact long-run rate.
  function automatic int tickMod(input int clkFreq, input int rate);
    return clkFreq / tickGcd(clkFreq, rate);
  endfunction

  function automatic int tickInc(input int clkFreq, input int rate);
    return rate / tickGcd(clkFreq, rate);
  endfunction

  function automatic int tickAccWidth(input int clkFreq, input int rate);
    return $clog2(tickMod(clkFreq, rate)) + 1;
  endfunction

endpackage

// File: rtl/rx_tick_gen.sv
// Free-running fractional-accumulator tick generator; one-clk tick at Rate Hz.
module rx_tick_gen
  import uart_pkg::*;
#(
  parameter int ClkFrequency = 50000000,
  parameter int Rate         = 921600
) (
  input  logic clk,
  input  logic rst_n,
  output logic tick
);

  localparam int W = tickAccWidth(ClkFrequency, Rate);
  localparam logic [W-1:0] INC = W'(tickInc(ClkFrequency, Rate));
  localparam logic [W-1:0] MOD = W'(tickMod(ClkFrequency, Rate));

  logic [W-1:0] acc, sum;

  assign sum = acc + INC;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc  <= '0;
      tick <= 1'b0;
    end else if (sum >= MOD) begin
      acc  <= sum - MOD;
      tick <= 1'b1;
    end else begin
      acc  <= sum;
      tick <= 1'b0;
    end
  end

endmodule

// File: rtl/async_receiver.sv
// 8N1 UART receiver: sync, majority filter, mid-bit sampling, framing and idle/EOP detect.
module async_receiver
  import uart_pkg::*;
#(
  parameter int ClkFrequency = 50000000,
  parameter int Baud         = 115200,
  parameter int Oversampling = 8
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       RxD,
  output logic       RxD_data_ready,
  output logic [7:0] RxD_data,
  output logic       RxD_framing_error,
  output logic       RxD_idle,
  output logic       RxD_endofpacket
);

  if (ClkFrequency < Baud * Oversampling || (Oversampling != 8 && Oversampling != 16)) begin : gBadParams
    $error("async_receiver: need ClkFrequency >= Baud*Oversampling and Oversampling of 8 or 16");
  end

  localparam int OS_W  = $clog2(Oversampling);
  localparam int GAP_W = OS_W + 2;
  localparam logic [OS_W-1:0]  SAMPLE_AT = OS_W'(Oversampling / 2 - 1);
  localparam logic [GAP_W-1:0] GAP_SAT   = {1'b1, {(GAP_W-1){1'b0}}};

  logic oversampleTick;

  rx_tick_gen #(
    .ClkFrequency(ClkFrequency),
    .Rate        (Baud * Oversampling)
  ) uTick (
    .clk  (clk),
    .rst_n(rst_n),
    .tick (oversampleTick)
  );

  logic [1:0]           rxSync, filtCnt, filtNext;
  logic                 rxBit;
  rx_state_t            state, stateNext;
  logic [OS_W-1:0]      bitCnt;
  logic [DATA_BITS-1:0] shift;
  logic [GAP_W-1:0]     gap;
  logic                 gotByte, sampleNow, idleRise;
  logic                 startDet, shiftEn, goodByte, frameErr;

  always_comb begin
    filtNext = filtCnt;
    if (rxSync[1] && filtCnt != FILTER_MAX)  filtNext = filtCnt + 2'd1;
    else if (!rxSync[1] && filtCnt != 2'd0)  filtNext = filtCnt - 2'd1;
  end

  assign sampleNow = oversampleTick && (state != IDLE) && (bitCnt == SAMPLE_AT);
  assign idleRise  = oversampleTick && (state == IDLE) && (gap == GAP_SAT - GAP_W'(1));
  assign RxD_idle  = gap[GAP_W-1];

  always_comb begin
    stateNext = state;
    startDet  = 1'b0;
    shiftEn   = 1'b0;
    goodByte  = 1'b0;
    frameErr  = 1'b0;
    case (state)
      IDLE:      if (oversampleTick && !rxBit) begin
                   stateNext = START;
                   startDet  = 1'b1;
                 end
      START:     if (sampleNow) stateNext = rxBit ? IDLE : D0;
      D0, D1, D2, D3, D4, D5, D6, D7:
                 if (sampleNow) begin
                   shiftEn   = 1'b1;
                   stateNext = (state == D7) ? STOP : rx_state_t'(state + 4'd1);
                 end
      STOP:      if (sampleNow) begin
                   goodByte  = rxBit;
                   frameErr  = !rxBit;
                   stateNext = rxBit ? IDLE : WAIT_HIGH;
                 end
      // A held-low line (break) parks here until the filtered line is high again.
      WAIT_HIGH: if (oversampleTick && rxBit) stateNext = IDLE;
      default:   stateNext = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rxSync            <= 2'b11;
      filtCnt           <= FILTER_MAX;
      rxBit             <= 1'b1;
      state             <= IDLE;
      bitCnt            <= '0;
      shift             <= '0;
      gap               <= GAP_SAT;
      gotByte           <= 1'b0;
      RxD_data          <= 8'h00;
      RxD_data_ready    <= 1'b0;
      RxD_framing_error <= 1'b0;
      RxD_endofpacket   <= 1'b0;
    end else begin
      rxSync <= {rxSync[0], RxD};
      if (oversampleTick) begin
        filtCnt <= filtNext;
        if (filtNext == FILTER_MAX) rxBit <= 1'b1;
        else if (filtNext == 2'd0)  rxBit <= 1'b0;
      end
      state <= stateNext;
      if (startDet)                           bitCnt <= '0;
      else if (oversampleTick && state != IDLE) bitCnt <= bitCnt + OS_W'(1);
      if (shiftEn) shift <= {rxBit, shift[DATA_BITS-1:1]};
      if (goodByte) RxD_data <= shift;
      RxD_data_ready    <= goodByte;
      RxD_framing_error <= frameErr;
      if (state != IDLE)                    gap <= '0;
      else if (oversampleTick && !gap[GAP_W-1]) gap <= gap + GAP_W'(1);
      RxD_endofpacket <= idleRise && gotByte;
      if (goodByte)      gotByte <= 1'b1;
      else if (idleRise) gotByte <= 1'b0;
    end
  end

endmodule

// File: doc/async_receiver.md
Name: async_receiver

Overview:
- UART receive companion to the async transmitter: 8N1 serial in, parallel byte out.
- Oversamples RxD and applies synchronisation, a majority-style filter, mid-bit sampling, framing check and idle/end-of-packet detection.
- Sits at the host-link input and feeds command/matrix bytes to the loader.
- Line format is identical to the transmitter: start 0, 8 data bits LSB first, stop 1.

Parameters:
- ClkFrequency, 50000000, system clock frequency in Hz.
- Baud, 115200, line rate in bit/s.
- Oversampling, 8, ticks per bit; legal values 8 or 16. Elaboration error if ClkFrequency < Baud*Oversampling.

Ports:
- clk  in  1  system clock; one clock domain only.
- rst_n  in  1  reset, asynchronous and active-low.
- RxD  in  1  serial line, asynchronous to clk, idle high.
- RxD_data_ready  out  1  one-clk pulse: a good byte has been placed on RxD_data.
- RxD_data  out  8  last good byte; held until the next good byte.
- RxD_framing_error  out  1  one-clk pulse: stop bit was sampled 0.
- RxD_idle  out  1  high while no frame has been seen for 2*Oversampling ticks.
- RxD_endofpacket  out  1  one-clk pulse when RxD_idle rises after at least one good byte.

Behaviour:
- Reset values: data_ready=0, data=8'h00, framing_error=0, idle=1, endofpacket=0, state=IDLE. Synchroniser flops, filter counter and filtered bit all reset to 1/high. rst_n asserted mid-frame aborts the frame with no pulses.
- Tick: sub-module generates OversampleTick at Baud*Oversampling, free-running (not gated).
- Sync: 2-flop synchroniser on RxD.
- Filter:
  - 2-bit saturating counter, updated on each tick: +1 if the synced input is 1, -1 if 0.
  - Filtered bit Rx_bit goes to 1 at count 3 and to 0 at count 0; otherwise it holds.
- Bit timer: OversamplingCnt (log2(Oversampling) bits), cleared on start detection, +1 per tick while not IDLE. SampleNow is the tick where the count reaches Oversampling/2-1 (mod Oversampling), i.e. once per bit at mid-bit.
- States:
  - IDLE: on a tick with Rx_bit==0, go to START.
  - START: on SampleNow, if Rx_bit==0 go to D0; else go to IDLE (glitch rejected, no pulse).
  - D0..D7: on SampleNow, shift Rx_bit into shift[7] (right shift) and advance; D7 goes to STOP.
  - STOP, on SampleNow:
    - Rx_bit==1: RxD_data <= shift; pulse data_ready next clk; go to IDLE.
    - Rx_bit==0: pulse framing_error; RxD_data unchanged; go to WAIT_HIGH.
  - WAIT_HIGH: stay until a tick with Rx_bit==1 (covers break conditions), then go to IDLE.
- Pulses are exactly 1 clk wide and registered. data_ready and framing_error are never high together.
- Latency: data_ready pulses about 9.5 bit times plus ≤2 clk plus ≤3 ticks after the RxD falling start edge.
- Idle detection:
  - Gap counter (log2(Oversampling)+2 bits) clears whenever state!=IDLE; in IDLE it +1 per tick, saturating at MSB set.
  - RxD_idle = gap MSB.
  - endofpacket pulses on the clk where idle rises, only if a good byte was received since the last endofpacket (sticky flag, cleared by the pulse).
- Back-to-back frames: a start edge immediately after the stop-bit sample must be captured; no extra idle time is required.

Decomposition:
- Package uart_pkg:
  - rx_state_t enum {IDLE, START, D0..D7, STOP, WAIT_HIGH}.
  - Constants: DATA_BITS=8, FILTER_MAX=2'd3.
  - Function computing tick accumulator width and increment from ClkFrequency, Baud and Oversampling.
- Sub-module rx_tick_gen:
  - Fractional accumulator tick generator; params ClkFrequency and Baud*Oversampling; ports clk, rst_n, tick.
  - Shareable with the transmitter's tick path.

Test Plan:
- Bench parameters: ClkFrequency=921600, Baud=115200, Oversampling=8, so one tick per clk and 8 clk per bit.
- Send 0x55 with a clean frame → single data_ready pulse 78–82 clk after the start edge; RxD_data=8'h55; framing_error stays 0.
- Send 0xA3, 0x00, 0xFF back-to-back, no gap → exactly three data_ready pulses with data A3, 00, FF in order. Then after 16 idle ticks → RxD_idle=1 and one endofpacket pulse; a further idle period gives no second pulse.
- 2-clk low glitch on idle RxD → no data_ready, no framing_error; RxD_data unchanged. Also, a 1-clk glitch inside a data bit of 0x0F → byte still received as 0x0F.
- Frame 0x3C with stop bit driven 0, then line held low 40 clk → one framing_error pulse, no data_ready, RxD_data keeps the previous value. After the line returns high, 0x81 is received correctly.
- rst_n pulsed low during D4 of a 0x77 frame → all outputs at reset values, no pulses; the next 0x12 frame is received correctly.
- Baud mismatch ±3% (bit width 8 vs 7.75/8.25 clk, via fractional bench timing) for 0xC5 → byte received correctly.
